// File: rtl/ads131_frame_unpacker.sv
// ads131_frame_unpacker: splits ADS131A0x SPI frames into status, sign-extended samples and frame events.
// Optional trailing CRC-16-CCITT word check is enabled by defining ADS_FRAME_CRC_EN.
module ads131_frame_unpacker #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 24
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [31:0] sample_data,
    output logic [15:0] status_word,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_short,
    output logic        err_stray,
    output logic        crc_err
);
`ifdef ADS_FRAME_CRC_EN
    typedef enum logic [2:0] {IDLE, ST_STATUS, ST_CHAN, ST_CRC, ST_DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ST_STATUS, ST_CHAN, ST_DONE} state_t;
`endif
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    state_t      state_q, state_d;
    logic [2:0]  ch_idx_q, ch_idx_d;
    logic        sample_valid_q, sample_valid_d;
    logic [2:0]  sample_ch_q, sample_ch_d;
    logic [31:0] sample_data_q, sample_data_d;
    logic [15:0] status_word_q, status_word_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        err_short_q, err_short_d;
    logic        err_stray_q, err_stray_d;
`ifdef ADS_FRAME_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_err_q, crc_err_d;
    function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction
`endif
    always_comb begin
        state_d        = state_q;
        ch_idx_d       = ch_idx_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
        status_word_d  = status_word_q;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count_q;
        err_short_d    = 1'b0;
        err_stray_d    = 1'b0;
`ifdef ADS_FRAME_CRC_EN
        crc_d          = crc_q;
        crc_err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = ST_STATUS;
                else if (word_valid) err_stray_d = 1'b1;
            end
            ST_STATUS: begin
                if (frame_start) err_short_d = 1'b1;
                else if (word_valid) begin
                    status_word_d = word_data[31:16];
                    ch_idx_d      = 3'd0;
                    state_d       = ST_CHAN;
`ifdef ADS_FRAME_CRC_EN
                    crc_d         = crc24(crc_q, word_data[31:8]);
`endif
                end
            end
            ST_CHAN: begin
                if (frame_start) begin
                    err_short_d = 1'b1;
                    state_d     = ST_STATUS;
                end else if (word_valid) begin
                    sample_valid_d = 1'b1;
                    sample_ch_d    = ch_idx_q;
                    sample_data_d  = $signed(word_data) >>> (32 - SAMPLE_W);
                    ch_idx_d       = ch_idx_q + 3'd1;
`ifdef ADS_FRAME_CRC_EN
                    crc_d          = crc24(crc_q, word_data[31:8]);
                    if (ch_idx_q == LAST_CH) state_d = ST_CRC;
`else
                    if (ch_idx_q == LAST_CH) begin
                        state_d       = ST_DONE;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end
`endif
                end
            end
`ifdef ADS_FRAME_CRC_EN
            ST_CRC: begin
                if (frame_start) begin
                    err_short_d = 1'b1;
                    state_d     = ST_STATUS;
                end else if (word_valid) begin
                    state_d       = ST_DONE;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    crc_err_d     = word_data[31:16] != crc_q;
                end
            end
`endif
            ST_DONE: state_d = frame_start ? ST_STATUS : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ADS_FRAME_CRC_EN
        if (frame_start) crc_d = 16'hFFFF;
`endif
    end
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ch_idx_q       <= 3'd0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 3'd0;
            sample_data_q  <= 32'd0;
            status_word_q  <= 16'd0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= 16'd0;
            err_short_q    <= 1'b0;
            err_stray_q    <= 1'b0;
`ifdef ADS_FRAME_CRC_EN
            crc_q          <= 16'hFFFF;
            crc_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ch_idx_q       <= ch_idx_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            status_word_q  <= status_word_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
            err_short_q    <= err_short_d;
            err_stray_q    <= err_stray_d;
`ifdef ADS_FRAME_CRC_EN
            crc_q          <= crc_d;
            crc_err_q      <= crc_err_d;
`endif
        end
    end
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign status_word  = status_word_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;
    assign err_short    = err_short_q;
    assign err_stray    = err_stray_q;
`ifdef ADS_FRAME_CRC_EN
    assign crc_err      = crc_err_q;
`else
    assign crc_err      = 1'b0;
`endif
endmodule

// File: tb/tb_ads131_frame_unpacker.sv
// tb_ads131_frame_unpacker: table vectors, directed corner sequences and random traffic vs a word-position model.
module tb_ads131_frame_unpacker;
    localparam int N = 4;
`ifdef ADS_FRAME_CRC_EN
    localparam int CRCW = 1;
`else
    localparam int CRCW = 0;
`endif
    logic        system_clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = 32'd0;
    logic        sample_valid, frame_done, err_short, err_stray, crc_err;
    logic [2:0]  sample_ch;
    logic [31:0] sample_data;
    logic [15:0] status_word, frame_count;

    ads131_frame_unpacker #(.NUM_CH(N), .SAMPLE_W(24)) dut (
        .system_clock(system_clock), .reset_n(reset_n), .frame_start(frame_start),
        .word_valid(word_valid), .word_data(word_data), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .sample_data(sample_data), .status_word(status_word),
        .frame_done(frame_done), .frame_count(frame_count), .err_short(err_short),
        .err_stray(err_stray), .crc_err(crc_err)
    );

    always #5 system_clock = ~system_clock;

    int errors = 0;
    int checks = 0;
    int m_mode = 0;
    int m_pos = 0;
    logic [15:0] m_crcv = 16'hFFFF;
    logic        e_sv = 0, e_fd = 0, e_short = 0, e_stray = 0, e_crc = 0;
    logic [2:0]  e_ch = 0;
    logic [31:0] e_sd = 0;
    logic [15:0] e_st = 0, e_fc = 0;

    typedef struct {
        bit          fs;
        bit          wv;
        logic [31:0] wd;
        bit          sv;
        logic [2:0]  ch;
        logic [31:0] sd;
        logic [15:0] st;
        bit          fd;
        logic [15:0] fc;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 2; b >= 0; b--) begin
            r = r ^ {d[8*b +: 8], 8'h00};
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit fs, input bit wv, input logic [31:0] wd);
        int s;
        e_sv = 0; e_fd = 0; e_short = 0; e_stray = 0; e_crc = 0;
        if (rst) begin
            m_mode = 0; e_st = 0; e_fc = 0;
        end else if (m_mode == 2) begin
            m_mode = fs ? 1 : 0; m_pos = 0; m_crcv = 16'hFFFF;
        end else if (fs) begin
            e_short = (m_mode == 1); m_mode = 1; m_pos = 0; m_crcv = 16'hFFFF;
        end else if (wv && m_mode == 0) begin
            e_stray = 1;
        end else if (wv) begin
            if (m_pos == 0) e_st = wd[31:16];
            else if (m_pos <= N) begin
                s = int'(wd[31:8]);
                if (s >= 2**23) s = s - 2**24;
                e_sv = 1; e_ch = 3'(m_pos - 1); e_sd = s;
            end else e_crc = (wd[31:16] != m_crcv);
            if (m_pos <= N) m_crcv = m_crc(m_crcv, wd[31:8]);
            m_pos++;
            if (m_pos == N + 1 + CRCW) begin
                e_fd = 1; e_fc = e_fc + 16'd1; m_mode = 2;
            end
        end
    endtask

    task automatic tick(input bit fs, input bit wv, input logic [31:0] wd, input string tag);
        frame_start = fs; word_valid = wv; word_data = wd;
        model_step(!reset_n, fs, wv, wd);
        @(negedge system_clock);
        check({tag, " flags/status/count"},
              {sample_valid, frame_done, err_short, err_stray, crc_err, status_word, frame_count},
              {e_sv, e_fd, e_short, e_stray, e_crc, e_st, e_fc});
        if (e_sv) check({tag, " ch/data"}, {sample_ch, sample_data}, {e_ch, e_sd});
    endtask

    task automatic send_frame(input logic [15:0] st, input bit flip, input string tag);
        logic [15:0] c;
        logic [31:0] w;
        c = 16'hFFFF;
        tick(1, 0, 32'd0, tag);
        w = {st, 16'($urandom)};
        tick(0, 1, w, tag);
        c = m_crc(c, w[31:8]);
        for (int i = 0; i < N; i++) begin
            w = $urandom;
            tick(0, 1, w, tag);
            c = m_crc(c, w[31:8]);
        end
        if (CRCW == 1) tick(0, 1, {c ^ {15'd0, flip}, 16'h0000}, tag);
        tick(0, 0, 32'd0, tag);
    endtask

    initial begin
        logic [15:0] c;
        @(negedge system_clock);
        tick(0, 0, 32'd0, "init");
        tick(0, 0, 32'd0, "init");
        reset_n = 1'b1;
        // T1: reset asserted part-way through a frame
        tick(1, 0, 32'd0, "T1");
        tick(0, 1, 32'h5555_0000, "T1");
        tick(0, 1, 32'h1234_5600, "T1");
        tick(0, 1, 32'h8765_4300, "T1");
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'($urandom), 1'($urandom), $urandom, "T1 rst");
        check("T1 zero flags", {sample_valid, frame_done, err_short, err_stray, crc_err, sample_ch, status_word, frame_count}, 64'd0);
        check("T1 zero data", sample_data, 64'd0);
        reset_n = 1'b1;
        // T2: nominal frame from the datasheet example
        c = 16'hFFFF;
        c = m_crc(c, 24'h220000); c = m_crc(c, 24'h7FFFFF); c = m_crc(c, 24'h800000);
        c = m_crc(c, 24'h000001); c = m_crc(c, 24'hFFFFFF);
        vecs.push_back('{1, 0, 32'h0000_0000, 0, 3'd0, 32'h0, 16'h0000, 0, 16'd0});
        vecs.push_back('{0, 1, 32'h2200_0000, 0, 3'd0, 32'h0, 16'h2200, 0, 16'd0});
        vecs.push_back('{0, 1, 32'h7FFF_FF00, 1, 3'd0, 32'h007F_FFFF, 16'h2200, 0, 16'd0});
        vecs.push_back('{0, 1, 32'h8000_0000, 1, 3'd1, 32'hFF80_0000, 16'h2200, 0, 16'd0});
        vecs.push_back('{0, 1, 32'h0000_0100, 1, 3'd2, 32'h0000_0001, 16'h2200, 0, 16'd0});
        if (CRCW == 1) begin
            vecs.push_back('{0, 1, 32'hFFFF_FF00, 1, 3'd3, 32'hFFFF_FFFF, 16'h2200, 0, 16'd0});
            vecs.push_back('{0, 1, {c, 16'h0000}, 0, 3'd0, 32'h0, 16'h2200, 1, 16'd1});
        end else
            vecs.push_back('{0, 1, 32'hFFFF_FF00, 1, 3'd3, 32'hFFFF_FFFF, 16'h2200, 1, 16'd1});
        vecs.push_back('{0, 0, 32'h0000_0000, 0, 3'd0, 32'h0, 16'h2200, 0, 16'd1});
        vecs.push_back('{0, 0, 32'h0000_0000, 0, 3'd0, 32'h0, 16'h2200, 0, 16'd1});
        foreach (vecs[i]) begin
            tick(vecs[i].fs, vecs[i].wv, vecs[i].wd, "T2 model");
            check("T2 table sv/fd/st/fc", {sample_valid, frame_done, status_word, frame_count},
                  {vecs[i].sv, vecs[i].fd, vecs[i].st, vecs[i].fc});
            if (vecs[i].sv) check("T2 table ch/data", {sample_ch, sample_data}, {vecs[i].ch, vecs[i].sd});
        end
        // T3: short frame, then a frame restarted in the done cycle
        tick(1, 0, 32'd0, "T3");
        tick(0, 1, 32'hABCD_0000, "T3");
        tick(0, 1, 32'h0100_0000, "T3");
        tick(0, 1, 32'h0200_0000, "T3");
        tick(1, 0, 32'd0, "T3");
        check("T3 err_short", err_short, 64'd1);
        check("T3 count held", frame_count, 64'd1);
        tick(0, 1, 32'h3300_0000, "T3");
        for (int i = 0; i < N + CRCW; i++) tick(0, 1, (CRCW == 1 && i == N) ? 32'd0 : $urandom, "T3");
        check("T3 count after", {frame_done, frame_count}, {1'b1, 16'd2});
        tick(1, 0, 32'd0, "T3 restart");
        check("T3 no short in done", err_short, 64'd0);
        tick(0, 1, 32'h4400_0000, "T3 restart");
        check("T3 restart status", status_word, 64'h4400);
        for (int i = 0; i < N + CRCW; i++) tick(0, 1, $urandom, "T3 restart");
        tick(0, 0, 32'd0, "T3");
        // T4: stray word and frame_start/word_valid priority
        tick(0, 1, 32'h7777_7700, "T4");
        check("T4 stray", {err_stray, sample_valid}, {1'b1, 1'b0});
        tick(1, 1, 32'hAAAA_0000, "T4");
        check("T4 no stray on start", err_stray, 64'd0);
        tick(0, 1, 32'h1234_0000, "T4");
        check("T4 status taken", status_word, 64'h1234);
        for (int i = 0; i < N + CRCW; i++) tick(0, 1, $urandom, "T4");
        tick(0, 0, 32'd0, "T4");
        // T5: counter wrap
        force dut.frame_count_q = 16'hFFFF;
        @(negedge system_clock);
        release dut.frame_count_q;
        e_fc = 16'hFFFF;
        check("T5 preload", frame_count, 64'hFFFF);
        send_frame(16'h5A5A, 0, "T5");
        check("T5 wrap", frame_count, 64'h0000);
`ifdef ADS_FRAME_CRC_EN
        // T6: CRC good and bad
        send_frame(16'h2200, 0, "T6 good");
        send_frame(16'h2200, 1, "T6 bad");
`endif
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, $urandom, "rand");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
